// File: rtl/id_stage_controller_pkg.sv
// ---------------------------------------------------------------------------
// id_stage_controller_pkg
// Shared definitions for the RV32IM decode-stage sequencer:
//   - RV32 base opcode constants recognised by the decoder
//   - immSel_t : immediate-type codes driven to the immediate generator
//   - ctrl_t   : control bits carried down the pipeline
//   - idEx_t   : full contents of the ID/EX control pipeline register
//   - ID_EX_BUBBLE : the value loaded into ID/EX to insert a bubble
// ---------------------------------------------------------------------------
package id_stage_controller_pkg;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   // IMM_IU (110) is a reserved code; the decoder never produces it.
   typedef enum logic [2:0] {
      IMM_U     = 3'b000,
      IMM_J     = 3'b001,
      IMM_S     = 3'b010,
      IMM_B     = 3'b011,
      IMM_I     = 3'b100,
      IMM_SHIFT = 3'b101,
      IMM_IU    = 3'b110,
      IMM_NONE  = 3'b111
   } immSel_t;

   typedef struct packed {
      logic regWrite;
      logic memRead;
      logic memWrite;
      logic branch;
      logic jump;
      logic aluSrcImm;
   } ctrl_t;

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [2:0] funct3;
      ctrl_t      ctrl;
   } idEx_t;

   localparam ctrl_t CTRL_NONE    = '0;
   localparam idEx_t ID_EX_BUBBLE = '0;

endpackage

// File: rtl/id_stage_controller_decoder.sv
// ---------------------------------------------------------------------------
// id_decoder
// Purely combinational instruction decoder for the ID stage.
// Ports:
//   i_opcode   [6:0]  opcode field of the IF/ID instruction
//   i_funct3   [2:0]  funct3 field (selects shift immediates for OP-IMM)
//   i_valid           instruction is real (0 = bubble)
//   o_immSel   [2:0]  immediate type for the immediate generator
//   o_ctrl            control bits for the ID/EX register
//   o_rs1Used         instruction reads rs1 (hazard check)
//   o_rs2Used         instruction reads rs2 (hazard check)
//   o_illegal         valid instruction with an unrecognised opcode
// ---------------------------------------------------------------------------
module id_decoder
   import id_stage_controller_pkg::*;
(
   input  logic [6:0] i_opcode,
   input  logic [2:0] i_funct3,
   input  logic       i_valid,
   output logic [2:0] o_immSel,
   output ctrl_t      o_ctrl,
   output logic       o_rs1Used,
   output logic       o_rs2Used,
   output logic       o_illegal
);

   immSel_t w_immSel;
   ctrl_t   w_ctrl;
   logic    w_rs1Used;
   logic    w_rs2Used;
   logic    w_known;

   // Opcode decode. Unknown opcodes and bubbles fall back to "no immediate",
   // no control bits and no register reads, so they can never stall the pipe.
   always_comb begin
      w_immSel  = IMM_NONE;
      w_ctrl    = CTRL_NONE;
      w_rs1Used = 1'b0;
      w_rs2Used = 1'b0;
      w_known   = 1'b1;
      case (i_opcode)
         OPC_LUI, OPC_AUIPC: begin
            w_immSel           = IMM_U;
            w_ctrl.regWrite    = 1'b1;
            w_ctrl.aluSrcImm   = 1'b1;
         end
         OPC_JAL: begin
            w_immSel           = IMM_J;
            w_ctrl.regWrite    = 1'b1;
            w_ctrl.jump        = 1'b1;
         end
         OPC_JALR: begin
            w_immSel           = IMM_I;
            w_ctrl.regWrite    = 1'b1;
            w_ctrl.jump        = 1'b1;
            w_ctrl.aluSrcImm   = 1'b1;
            w_rs1Used          = 1'b1;
         end
         OPC_BRANCH: begin
            w_immSel           = IMM_B;
            w_ctrl.branch      = 1'b1;
            w_rs1Used          = 1'b1;
            w_rs2Used          = 1'b1;
         end
         OPC_LOAD: begin
            w_immSel           = IMM_I;
            w_ctrl.regWrite    = 1'b1;
            w_ctrl.memRead     = 1'b1;
            w_ctrl.aluSrcImm   = 1'b1;
            w_rs1Used          = 1'b1;
         end
         OPC_STORE: begin
            w_immSel           = IMM_S;
            w_ctrl.memWrite    = 1'b1;
            w_ctrl.aluSrcImm   = 1'b1;
            w_rs1Used          = 1'b1;
            w_rs2Used          = 1'b1;
         end
         OPC_OPIMM: begin
            // SLTIU keeps the signed I immediate; only shifts use the shamt form.
            w_immSel           = (i_funct3 == 3'b001 || i_funct3 == 3'b101) ? IMM_SHIFT : IMM_I;
            w_ctrl.regWrite    = 1'b1;
            w_ctrl.aluSrcImm   = 1'b1;
            w_rs1Used          = 1'b1;
         end
         OPC_OP: begin
            w_immSel           = IMM_NONE;
            w_ctrl.regWrite    = 1'b1;
            w_rs1Used          = 1'b1;
            w_rs2Used          = 1'b1;
         end
         default: begin
            w_known            = 1'b0;
         end
      endcase
      if (!i_valid) begin
         w_immSel  = IMM_NONE;
         w_ctrl    = CTRL_NONE;
         w_rs1Used = 1'b0;
         w_rs2Used = 1'b0;
      end
   end

   assign o_immSel  = w_immSel;
   assign o_ctrl    = w_ctrl;
   assign o_rs1Used = w_rs1Used;
   assign o_rs2Used = w_rs2Used;
   assign o_illegal = i_valid & ~w_known;

endmodule

// File: rtl/id_stage_controller.sv
// ---------------------------------------------------------------------------
// id_stage_controller
// Decode-stage sequencer: decodes IF/ID, owns the ID/EX control register,
// inserts load-use bubbles, freezes for multi-cycle EX and applies flushes
// (deferring a flush that arrives while EX is frozen).
// Ports:
//   CLK, RESET (async, active-low)
//   INSTR[31:0], ID_VALID         instruction in IF/ID
//   EX_BUSY                       multi-cycle EX unit busy, freeze ID/EX
//   FLUSH                         taken branch/jump in EX, kill ID instruction
//   IMM_SEL[2:0], ILLEGAL         combinational decode of the ID instruction
//   STALL                         hold PC and IF/ID this cycle
//   EX_VALID, EX_RD/RS1/RS2, EX_FUNCT3, EX_* control bits   ID/EX contents
//   STALL_COUNT                   saturating count of load-use bubbles
// ---------------------------------------------------------------------------
module id_stage_controller
   import id_stage_controller_pkg::*;
#(
   parameter int STALL_CNT_W = 16
)(
   input  logic                   CLK,
   input  logic                   RESET,
   input  logic [31:0]            INSTR,
   input  logic                   ID_VALID,
   input  logic                   EX_BUSY,
   input  logic                   FLUSH,
   output logic [2:0]             IMM_SEL,
   output logic                   STALL,
   output logic                   ILLEGAL,
   output logic                   EX_VALID,
   output logic [4:0]             EX_RD,
   output logic [4:0]             EX_RS1,
   output logic [4:0]             EX_RS2,
   output logic [2:0]             EX_FUNCT3,
   output logic                   EX_REG_WRITE,
   output logic                   EX_MEM_READ,
   output logic                   EX_MEM_WRITE,
   output logic                   EX_BRANCH,
   output logic                   EX_JUMP,
   output logic                   EX_ALU_SRC_IMM,
   output logic [STALL_CNT_W-1:0] STALL_COUNT
);

   localparam logic [STALL_CNT_W-1:0] CNT_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

   idEx_t                  r_idEx;
   logic                   r_flushPending;
   logic [STALL_CNT_W-1:0] r_stallCount;

   ctrl_t                  w_ctrl;
   logic                   w_rs1Used;
   logic                   w_rs2Used;
   logic                   w_illegal;
   idEx_t                  w_decoded;
   logic                   w_hazard;
   logic                   w_flushNow;
   logic                   w_unusedInstrHi;

   id_decoder u_decoder (
      .i_opcode  (INSTR[6:0]),
      .i_funct3  (INSTR[14:12]),
      .i_valid   (ID_VALID),
      .o_immSel  (IMM_SEL),
      .o_ctrl    (w_ctrl),
      .o_rs1Used (w_rs1Used),
      .o_rs2Used (w_rs2Used),
      .o_illegal (w_illegal)
   );

   // The immediate bits above rs2 are consumed by the immediate generator, not here.
   assign w_unusedInstrHi = ^INSTR[31:25];

   // Next ID/EX value for a live instruction; the decoder already zeroes the
   // control bits for bubbles and illegal opcodes.
   always_comb begin
      w_decoded        = ID_EX_BUBBLE;
      w_decoded.valid  = ID_VALID & ~w_illegal;
      w_decoded.rd     = INSTR[11:7];
      w_decoded.rs1    = INSTR[19:15];
      w_decoded.rs2    = INSTR[24:20];
      w_decoded.funct3 = INSTR[14:12];
      w_decoded.ctrl   = w_ctrl;
   end

   // Load-use check against the current ID/EX contents; a store's data
   // register counts because there is no store-data forwarding.
   assign w_hazard = ID_VALID & r_idEx.valid & r_idEx.ctrl.memRead & (r_idEx.rd != 5'd0) &
                     ((w_rs1Used & (INSTR[19:15] == r_idEx.rd)) |
                      (w_rs2Used & (INSTR[24:20] == r_idEx.rd)));

   assign w_flushNow = FLUSH | r_flushPending;

   // A flush outranks a hazard, so the hazard stall is only raised when no flush applies.
   assign STALL   = EX_BUSY | (~w_flushNow & w_hazard);
   assign ILLEGAL = w_illegal;

   // ID/EX register, deferred flush and stall counter, in priority order:
   // freeze, flush, load-use bubble, normal advance.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_idEx         <= ID_EX_BUBBLE;
         r_flushPending <= 1'b0;
         r_stallCount   <= '0;
      end else if (EX_BUSY) begin
         if (FLUSH) begin
            r_flushPending <= 1'b1;
         end
      end else if (w_flushNow) begin
         r_idEx         <= ID_EX_BUBBLE;
         r_flushPending <= 1'b0;
      end else if (w_hazard) begin
         r_idEx <= ID_EX_BUBBLE;
         if (r_stallCount != '1) begin
            r_stallCount <= r_stallCount + CNT_ONE;
         end
      end else begin
         r_idEx <= w_decoded;
      end
   end

   assign EX_VALID       = r_idEx.valid;
   assign EX_RD          = r_idEx.rd;
   assign EX_RS1         = r_idEx.rs1;
   assign EX_RS2         = r_idEx.rs2;
   assign EX_FUNCT3      = r_idEx.funct3;
   assign EX_REG_WRITE   = r_idEx.ctrl.regWrite;
   assign EX_MEM_READ    = r_idEx.ctrl.memRead;
   assign EX_MEM_WRITE   = r_idEx.ctrl.memWrite;
   assign EX_BRANCH      = r_idEx.ctrl.branch;
   assign EX_JUMP        = r_idEx.ctrl.jump;
   assign EX_ALU_SRC_IMM = r_idEx.ctrl.aluSrcImm;
   assign STALL_COUNT    = r_stallCount;

endmodule
